// File: rtl/sw_cfg_loader.sv
// -----------------------------------------------------------------------------
// sw_cfg_loader
//
// Builds the switch-enable vector for the channel-to-capacitor mux array from a
// byte stream. The frame is first assembled in a shadow register. Its enabled
// bits are then counted one per cycle. A frame that enables more capacitors
// than there are live channels is rejected. A good frame reaches the live sw
// output only on an apply strobe, so the mux never sees a partial or illegal
// pattern.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   cfg_valid  in   byte-stream valid
//   cfg_ready  out  byte-stream ready (high in IDLE/LOAD only)
//   cfg_data   in   frame byte; byte k carries sw[8k+7:8k], byte 0 first
//   ch_active  in   number of live channels, compared with the popcount
//   apply      in   commit strobe, acted on only while a frame is pending
//   err_clr    in   clears cfg_err (a simultaneous reject wins)
//   sw         out  live switch vector
//   sw_count   out  popcount of live sw
//   sw_update  out  one-cycle pulse after each commit
//   cfg_busy   out  high while counting, checking or pending
//   cfg_err    out  sticky frame-rejected flag
// -----------------------------------------------------------------------------
module sw_cfg_loader #(
  parameter int CAPACITOR_NUM = 70,
  parameter int CHANNEL_NUM   = 128,
  parameter int NBYTES        = (CAPACITOR_NUM + 7) / 8,
  parameter int CW            = $clog2(CHANNEL_NUM + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [7:0]               cfg_data,
  input  logic [CW-1:0]            ch_active,
  input  logic                     apply,
  input  logic                     err_clr,
  output logic [CAPACITOR_NUM-1:0] sw,
  output logic [CW-1:0]            sw_count,
  output logic                     sw_update,
  output logic                     cfg_busy,
  output logic                     cfg_err
);

  localparam int BW = $clog2(NBYTES + 1);
  localparam int IW = $clog2(CAPACITOR_NUM + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_PEND  = 3'd4;

  logic [2:0]               state_q,     state_d;
  logic [BW-1:0]            byte_cnt_q,  byte_cnt_d;
  logic [IW-1:0]            bit_cnt_q,   bit_cnt_d;
  logic [CW-1:0]            pop_q,       pop_d;
  logic [CAPACITOR_NUM-1:0] shadow_q,    shadow_d;
  logic [CAPACITOR_NUM-1:0] sw_q,        sw_d;
  logic [CW-1:0]            sw_count_q,  sw_count_d;
  logic                     sw_update_q, sw_update_d;
  logic                     err_q,       err_d;

  logic                     xfer;
  logic                     last_byte;
  logic                     last_bit;
  logic                     cur_bit;
  logic [CAPACITOR_NUM-1:0] shadow_wr;
  logic [CAPACITOR_NUM-1:0] shadow_new;

  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign cfg_busy  = (state_q == S_COUNT) || (state_q == S_CHECK) || (state_q == S_PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign last_byte = (byte_cnt_q == BW'(NBYTES - 1));
  assign last_bit  = (bit_cnt_q == IW'(CAPACITOR_NUM - 1));
  assign cur_bit   = shadow_q[bit_cnt_q];

  // Per-bit write enables: shadow bit gi belongs to byte gi/8. Only real
  // capacitor bits exist here, so pad bits of the last byte have no storage.
  generate
    for (genvar gi = 0; gi < CAPACITOR_NUM; gi++) begin : g_shadow_wr
      assign shadow_wr[gi]  = xfer && (byte_cnt_q == BW'(gi / 8));
      assign shadow_new[gi] = cfg_data[gi % 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    pop_d       = pop_q;
    shadow_d    = (shadow_q & ~shadow_wr) | (shadow_new & shadow_wr);
    sw_d        = sw_q;
    sw_count_d  = sw_count_q;
    sw_update_d = 1'b0;
    err_d       = err_clr ? 1'b0 : err_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (xfer) begin
          if (last_byte) begin
            state_d    = S_COUNT;
            byte_cnt_d = '0;
            bit_cnt_d  = '0;
            pop_d      = '0;
          end else begin
            state_d    = S_LOAD;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_COUNT: begin
        pop_d     = pop_q + {{(CW-1){1'b0}}, cur_bit};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          state_d   = S_CHECK;
          bit_cnt_d = '0;
        end
      end
      S_CHECK: begin
        if (pop_q <= ch_active) begin
          state_d = S_PEND;
        end else begin
          // Reject: the set overrides a simultaneous err_clr.
          err_d    = 1'b1;
          shadow_d = '0;
          state_d  = S_IDLE;
        end
      end
      S_PEND: begin
        if (apply) begin
          sw_d        = shadow_q;
          sw_count_d  = pop_q;
          sw_update_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      pop_q       <= '0;
      shadow_q    <= '0;
      sw_q        <= '0;
      sw_count_q  <= '0;
      sw_update_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      pop_q       <= pop_d;
      shadow_q    <= shadow_d;
      sw_q        <= sw_d;
      sw_count_q  <= sw_count_d;
      sw_update_q <= sw_update_d;
      err_q       <= err_d;
    end
  end

  assign sw        = sw_q;
  assign sw_count  = sw_count_q;
  assign sw_update = sw_update_q;
  assign cfg_err   = err_q;

endmodule
